mem_proto_checker: RTL and testbench
====================================

MEM_PROTO_CHECKER -- requirements
Module: mem_proto_checker

Interface
REQ-001 Parameters: WIDTH, default 8, data width in bits.
REQ-002 Parameters: ADDR_WIDTH, default 4, address width; shadow depth is 2**ADDR_WIDTH.
REQ-003 Parameters: MAX_LAT, default 4, maximum cycles valid may wait for ready (>=1).
REQ-004 Parameters: CNT_WIDTH, default 16, width of all counters.
REQ-005 Parameters: STRICT, default 0; 1 = reads of never-written addresses are errors.
REQ-006 Ports: clk  in  1  sole clock, rising edge.
REQ-007 Ports: res  in  1  reset; asynchronous, active-low.
REQ-008 Ports: wr_rd  in  1  1 = write, 0 = read; observed bus.
REQ-009 Ports: valid, ready  in  1 each  observed bus handshake.
REQ-010 Ports: addr  in  ADDR_WIDTH  observed address.
REQ-011 Ports: wdata, rdata  in  WIDTH each  observed write/read data.
REQ-012 Ports: clr_err  in  1  synchronous clear of flags, err_cnt, first-error capture.
REQ-013 Ports: err_flags  out  5  sticky: [0] TIMEOUT, [1] UNSTABLE, [2] SPURIOUS, [3] MISMATCH, [4] UNINIT.
REQ-014 Ports: err_any  out  1  OR of err_flags.
REQ-015 Ports: err_cnt  out  CNT_WIDTH  total error events, saturating.
REQ-016 Ports: first_err_code  out  3  index of first error flag set; first_err_addr  out  ADDR_WIDTH  addr sampled with it.
REQ-017 Ports: wr_cnt, rd_cnt  out  CNT_WIDTH each  completed write/read transfers, saturating.

Function
REQ-018 Transfer occurs on a rising edge with valid=1 and ready=1; rdata is sampled in that same cycle; the checker is purely passive.
REQ-019 FSM states IDLE, WAIT, LATE; IDLE->WAIT on valid&&!ready; WAIT->IDLE on transfer or valid drop; WAIT->LATE when wait counter reaches MAX_LAT; LATE->IDLE on transfer or valid drop.
REQ-020 Wait counter clears in IDLE, increments each WAIT cycle; TIMEOUT raised once per transaction, on WAIT->LATE.
REQ-021 In WAIT/LATE, sample wr_rd, addr and (writes) wdata on entry; any change before transfer raises UNSTABLE once per transaction.
REQ-022 valid dropping in WAIT/LATE without transfer raises UNSTABLE.
REQ-023 ready=1 with valid=0 raises SPURIOUS each such cycle.
REQ-024 Write transfer: shadow[addr] <= wdata, written bit[addr] <= 1, wr_cnt increments; effective from next cycle.
REQ-025 Read transfer with written bit set and rdata != shadow[addr] raises MISMATCH; rd_cnt increments regardless.
REQ-026 Read transfer with written bit clear raises UNINIT when STRICT=1; no check when STRICT=0.
REQ-027 Multiple errors in one cycle: all flags set; err_cnt adds count of events, saturating at 2**CNT_WIDTH-1; first_err_code = lowest index among them.
REQ-028 first_err_code/addr captured only when err_any was 0 before the edge.
REQ-029 clr_err together with new error: clear applies, then new error recorded (flag set, err_cnt = event count, capture taken).
REQ-030 clr_err does not affect FSM, shadow, written bits, wr_cnt, rd_cnt.
REQ-031 wr_cnt/rd_cnt saturate at 2**CNT_WIDTH-1.

Reset
REQ-032 res=0 forces asynchronously: FSM IDLE, wait counter 0, all written bits 0, all outputs 0; shadow data contents undefined.
REQ-033 Reset mid-transaction discards it; no error raised for it; checks resume on first edge with res=1.

Verification
REQ-034 Write addr 3 wdata 8'hA5 (ready same cycle), read addr 3 rdata 8'hA5 -> wr_cnt=1, rd_cnt=1, err_flags=0.
REQ-035 Write addr 3 8'hA5, read addr 3 rdata 8'h5A -> err_flags[3]=1, err_cnt=1, first_err_code=3, first_err_addr=3.
REQ-036 valid held, ready low 5 cycles (MAX_LAT=4) then high -> err_flags[0]=1 after 4th wait cycle, err_cnt=1, transfer counted.
REQ-037 addr changes 2->4 while valid=1, ready=0, and ready=1 with valid=0 in a later cycle -> err_flags=5'b00110, err_cnt=2, first_err_code=1.
REQ-038 STRICT=1, read addr 7 never written -> err_flags[4]=1; then clr_err pulse -> err_flags=0, err_cnt=0, rd_cnt unchanged.
REQ-039 Drive res=0 mid-WAIT with errors present -> all outputs 0 immediately; read of previously written addr afterwards raises no MISMATCH.

Source files
------------

// File: rtl/mem_proto_checker.sv
// Passive protocol checker for a valid/ready memory bus: tracks handshake timing,
// request stability and read-data coherence against a shadow copy of written data.
module mem_proto_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MAX_LAT    = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter bit          STRICT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  wr_rd,
  input  logic                  valid,
  input  logic                  ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  clr_err,
  output logic [4:0]            err_flags,
  output logic                  err_any,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [2:0]            first_err_code,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned LatW  = $clog2(MAX_LAT + 1);
  localparam int unsigned SumW  = CNT_WIDTH + 3;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StWait, StLate} state_e;

  state_e                state_q;
  logic [LatW-1:0]       wait_cnt_q;
  logic                  unst_seen_q;
  logic                  s_wr_rd_q;
  logic [ADDR_WIDTH-1:0] s_addr_q;
  logic [WIDTH-1:0]      s_wdata_q;
  logic [WIDTH-1:0]      shadow_q [Depth];
  logic [Depth-1:0]      written_q;
  logic [4:0]            flags_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [2:0]            code_q;
  logic [ADDR_WIDTH-1:0] faddr_q;
  logic [CNT_WIDTH-1:0]  wr_cnt_q;
  logic [CNT_WIDTH-1:0]  rd_cnt_q;

  logic                  xfer;
  logic                  stall;
  logic                  changed;
  logic [LatW-1:0]       wait_inc;
  logic [4:0]            ev;
  logic [2:0]            ev_num;
  logic [4:0]            flags_base;
  logic [CNT_WIDTH-1:0]  cnt_base;
  logic [SumW-1:0]       cnt_sum;
  logic [4:0]            flags_d;
  logic [CNT_WIDTH-1:0]  err_cnt_d;
  logic [2:0]            code_d;
  logic [ADDR_WIDTH-1:0] faddr_d;

  // Error events seen at this edge: [0] timeout .. [4] uninitialised read.
  always_comb begin
    xfer     = valid & ready;
    stall    = valid & ~ready;
    wait_inc = wait_cnt_q + LatW'(1);
    changed  = (wr_rd != s_wr_rd_q) || (addr != s_addr_q) ||
               (s_wr_rd_q && (wdata != s_wdata_q));
    ev    = '0;
    ev[0] = (state_q == StWait) && stall && (wait_inc >= LatW'(MAX_LAT));
    ev[1] = (state_q != StIdle) && !unst_seen_q && (!valid || changed);
    ev[2] = ready && !valid;
    ev[3] = xfer && !wr_rd && written_q[addr] && (rdata != shadow_q[addr]);
    ev[4] = STRICT && xfer && !wr_rd && !written_q[addr];
  end

  // A clear in the same cycle as new errors wipes the old state first.
  always_comb begin
    flags_base = clr_err ? '0 : flags_q;
    cnt_base   = clr_err ? '0 : err_cnt_q;
    ev_num     = {2'b00, ev[0]} + {2'b00, ev[1]} + {2'b00, ev[2]} +
                 {2'b00, ev[3]} + {2'b00, ev[4]};
    cnt_sum    = SumW'(cnt_base) + SumW'(ev_num);
    err_cnt_d  = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[CNT_WIDTH-1:0];
    flags_d    = flags_base | ev;
    code_d     = clr_err ? 3'd0 : code_q;
    faddr_d    = clr_err ? '0 : faddr_q;
    if ((ev != 5'd0) && (flags_base == 5'd0)) begin
      for (int i = 4; i >= 0; i--) begin
        if (ev[i]) code_d = 3'(i);
      end
      faddr_d = addr;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      unst_seen_q <= 1'b0;
      s_wr_rd_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      written_q   <= '0;
      flags_q     <= '0;
      err_cnt_q   <= '0;
      code_q      <= '0;
      faddr_q     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      flags_q   <= flags_d;
      err_cnt_q <= err_cnt_d;
      code_q    <= code_d;
      faddr_q   <= faddr_d;
      if (xfer && wr_rd) begin
        written_q[addr] <= 1'b1;
        if (wr_cnt_q != CntMax) wr_cnt_q <= wr_cnt_q + CntOne;
      end
      if (xfer && !wr_rd && (rd_cnt_q != CntMax)) rd_cnt_q <= rd_cnt_q + CntOne;

      case (state_q)
        StIdle: begin
          wait_cnt_q <= '0;
          if (stall) begin
            state_q     <= StWait;
            // The entry cycle is already the first stalled cycle.
            wait_cnt_q  <= LatW'(1);
            unst_seen_q <= 1'b0;
            s_wr_rd_q   <= wr_rd;
            s_addr_q    <= addr;
            s_wdata_q   <= wdata;
          end
        end
        StWait: begin
          if (!stall) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
          end else begin
            unst_seen_q <= unst_seen_q | ev[1];
            wait_cnt_q  <= wait_inc;
            if (ev[0]) state_q <= StLate;
          end
        end
        StLate: begin
          if (!stall) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
          end else begin
            unst_seen_q <= unst_seen_q | ev[1];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Shadow data is deliberately not reset; the written bits qualify it.
  always_ff @(posedge clk) begin
    if (xfer && wr_rd) shadow_q[addr] <= wdata;
  end

  assign err_flags      = flags_q;
  assign err_any        = |flags_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_code = code_q;
  assign first_err_addr = faddr_q;
  assign wr_cnt         = wr_cnt_q;
  assign rd_cnt         = rd_cnt_q;

endmodule

// File: tb/tb_mem_proto_checker.sv
// Bench for mem_proto_checker: directed scenarios plus random traffic against a
// transaction-level model; dut0 is lenient/16-bit counters, dut1 strict/3-bit counters.
module tb_mem_proto_checker;

  localparam int Max0   = 65535;
  localparam int Max1   = 7;
  localparam int MaxLat = 4;

  logic       clk = 1'b0;
  logic       res, wr_rd, valid, ready, clr_err;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;

  logic [4:0]  f0, f1;
  logic        any0, any1;
  logic [15:0] ec0, wc0, rc0;
  logic [2:0]  ec1, wc1, rc1;
  logic [2:0]  fc0, fc1;
  logic [3:0]  fa0, fa1;

  always #5 clk = ~clk;

  mem_proto_checker #(
    .WIDTH(8), .ADDR_WIDTH(4), .MAX_LAT(MaxLat), .CNT_WIDTH(16), .STRICT(1'b0)
  ) dut0 (
    .clk(clk), .res(res), .wr_rd(wr_rd), .valid(valid), .ready(ready), .addr(addr),
    .wdata(wdata), .rdata(rdata), .clr_err(clr_err), .err_flags(f0), .err_any(any0),
    .err_cnt(ec0), .first_err_code(fc0), .first_err_addr(fa0), .wr_cnt(wc0), .rd_cnt(rc0)
  );

  mem_proto_checker #(
    .WIDTH(8), .ADDR_WIDTH(4), .MAX_LAT(MaxLat), .CNT_WIDTH(3), .STRICT(1'b1)
  ) dut1 (
    .clk(clk), .res(res), .wr_rd(wr_rd), .valid(valid), .ready(ready), .addr(addr),
    .wdata(wdata), .rdata(rdata), .clr_err(clr_err), .err_flags(f1), .err_any(any1),
    .err_cnt(ec1), .first_err_code(fc1), .first_err_addr(fa1), .wr_cnt(wc1), .rd_cnt(rc1)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: one pending transaction plus memory image and error books.
  logic [7:0] m_shadow [16];
  bit         m_written [16];
  bit         busy, unst_rep, s_wr;
  int         stalls;
  logic [3:0] s_addr;
  logic [7:0] s_wdata;
  logic [4:0] m_flags [2];
  int         m_cnt [2], m_wc [2], m_rc [2];
  logic [2:0] m_fc [2];
  logic [3:0] m_fa [2];

  function automatic logic [60:0] act0();
    return {f0, any0, ec0, fc0, fa0, wc0, rc0};
  endfunction
  function automatic logic [21:0] act1();
    return {f1, any1, ec1, fc1, fa1, wc1, rc1};
  endfunction
  function automatic logic [60:0] exp0();
    return {m_flags[0], |m_flags[0], 16'(m_cnt[0]), m_fc[0], m_fa[0], 16'(m_wc[0]),
            16'(m_rc[0])};
  endfunction
  function automatic logic [21:0] exp1();
    return {m_flags[1], |m_flags[1], 3'(m_cnt[1]), m_fc[1], m_fa[1], 3'(m_wc[1]),
            3'(m_rc[1])};
  endfunction

  task automatic model_reset();
    busy = 0; unst_rep = 0; stalls = 0;
    for (int i = 0; i < 16; i++) m_written[i] = 0;
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = '0; m_cnt[k] = 0; m_wc[k] = 0; m_rc[k] = 0; m_fc[k] = '0; m_fa[k] = '0;
    end
  endtask

  task automatic model_step(input bit v, input bit r, input bit w, input logic [3:0] a,
                            input logic [7:0] wd, input logic [7:0] rd, input bit c);
    logic [4:0] ev;
    logic [4:0] e;
    bit uninit;
    int n, lim;
    ev = '0;
    uninit = 0;
    if (busy) begin
      if (!v) begin
        if (!unst_rep) ev[1] = 1'b1;
        busy = 0;
      end else begin
        if (!unst_rep && (w != s_wr || a != s_addr || (s_wr && wd != s_wdata))) begin
          ev[1] = 1'b1;
          unst_rep = 1;
        end
        if (r) busy = 0;
        else begin
          stalls++;
          if (stalls == MaxLat) ev[0] = 1'b1;
        end
      end
    end else if (v && !r) begin
      busy = 1; stalls = 1; unst_rep = 0; s_wr = w; s_addr = a; s_wdata = wd;
    end
    if (r && !v) ev[2] = 1'b1;
    if (v && r && !w) begin
      if (m_written[a] && rd != m_shadow[a]) ev[3] = 1'b1;
      uninit = !m_written[a];
    end
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? Max0 : Max1;
      e = ev;
      if (k == 1 && uninit) e[4] = 1'b1;
      if (v && r && w && m_wc[k] < lim) m_wc[k]++;
      if (v && r && !w && m_rc[k] < lim) m_rc[k]++;
      if (c) begin
        m_flags[k] = '0; m_cnt[k] = 0; m_fc[k] = '0; m_fa[k] = '0;
      end
      n = $countones(e);
      if (n != 0) begin
        if (m_flags[k] == 5'd0) begin
          for (int b = 4; b >= 0; b--) if (e[b]) m_fc[k] = 3'(b);
          m_fa[k] = a;
        end
        m_flags[k] = m_flags[k] | e;
        m_cnt[k] = (m_cnt[k] + n > lim) ? lim : m_cnt[k] + n;
      end
    end
    if (v && r && w) begin
      m_shadow[a] = wd;
      m_written[a] = 1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit v, input bit r, input bit w, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] rd, input bit c);
    valid = v; ready = r; wr_rd = w; addr = a; wdata = wd; rdata = rd; clr_err = c;
    model_step(v, r, w, a, wd, rd, c);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    res = 1'b0;
    valid = 0; ready = 0; wr_rd = 0; addr = '0; wdata = '0; rdata = '0; clr_err = 0;
    model_reset();
    @(negedge clk);
    res = 1'b1;
  endtask

  task automatic test_reset();
    res = 1'b0;
    valid = 0; ready = 0; wr_rd = 0; addr = '0; wdata = '0; rdata = '0; clr_err = 0;
    model_reset();
    @(negedge clk);
    n_total++;
    if (act0() !== 61'd0) $display("FAIL reset_dut0: got %h expected 0", act0());
    else n_pass++;
    n_total++;
    if (act1() !== 22'd0) $display("FAIL reset_dut1: got %h expected 0", act1());
    else n_pass++;
    res = 1'b1;
  endtask

  task automatic test_write_read();
    apply_reset();
    drive(1, 1, 1, 4'd3, 8'hA5, 8'h00, 0);
    drive(1, 1, 0, 4'd3, 8'h00, 8'hA5, 0);
    n_total++;
    if ({wc0, rc0, f0} !== {16'd1, 16'd1, 5'd0})
      $display("FAIL write_read: wr=%0d rd=%0d flags=%b expected 1 1 00000", wc0, rc0, f0);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    apply_reset();
    drive(1, 1, 1, 4'd3, 8'hA5, 8'h00, 0);
    drive(1, 1, 0, 4'd3, 8'h00, 8'h5A, 0);
    n_total++;
    if ({f0, any0, ec0, fc0, fa0} !== {5'b01000, 1'b1, 16'd1, 3'd3, 4'd3})
      $display("FAIL mismatch: flags=%b any=%b cnt=%0d code=%0d addr=%0d expected 01000 1 1 3 3",
               f0, any0, ec0, fc0, fa0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 1, 4'd5, 8'h11, 8'h00, 0);
      if (i == 3) begin
        n_total++;
        if (f0 !== 5'd0) $display("FAIL timeout_early: flags=%b expected 00000", f0);
        else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if ({f0, ec0} !== {5'b00001, 16'd1})
          $display("FAIL timeout_raise: flags=%b cnt=%0d expected 00001 1", f0, ec0);
        else n_pass++;
      end
    end
    drive(1, 1, 1, 4'd5, 8'h11, 8'h00, 0);
    n_total++;
    if ({f0, ec0, wc0} !== {5'b00001, 16'd1, 16'd1})
      $display("FAIL timeout_xfer: flags=%b cnt=%0d wr=%0d expected 00001 1 1", f0, ec0, wc0);
    else n_pass++;
  endtask

  task automatic test_unstable_spurious();
    apply_reset();
    drive(1, 0, 0, 4'd2, 8'h00, 8'h00, 0);
    drive(1, 0, 0, 4'd4, 8'h00, 8'h00, 0);
    drive(0, 1, 0, 4'd4, 8'h00, 8'h00, 0);
    n_total++;
    if ({f0, ec0, fc0, fa0} !== {5'b00110, 16'd2, 3'd1, 4'd4})
      $display("FAIL unstable_spurious: flags=%b cnt=%0d code=%0d addr=%0d expected 00110 2 1 4",
               f0, ec0, fc0, fa0);
    else n_pass++;
  endtask

  task automatic test_strict_clear();
    apply_reset();
    drive(1, 1, 0, 4'd7, 8'h00, 8'h33, 0);
    n_total++;
    if ({f1, rc1, f0} !== {5'b10000, 3'd1, 5'd0})
      $display("FAIL strict_uninit: f1=%b rd1=%0d f0=%b expected 10000 1 00000", f1, rc1, f0);
    else n_pass++;
    drive(0, 0, 0, 4'd0, 8'h00, 8'h00, 1);
    n_total++;
    if ({f1, ec1, fc1, rc1} !== {5'b00000, 3'd0, 3'd0, 3'd1})
      $display("FAIL strict_clear: f1=%b cnt=%0d code=%0d rd1=%0d expected 00000 0 0 1",
               f1, ec1, fc1, rc1);
    else n_pass++;
  endtask

  task automatic test_clr_with_error();
    apply_reset();
    drive(1, 0, 0, 4'd1, 8'h00, 8'h00, 0);
    drive(1, 0, 0, 4'd6, 8'h00, 8'h00, 0);
    drive(1, 1, 0, 4'd6, 8'h00, 8'h00, 0);
    drive(0, 1, 0, 4'd9, 8'h00, 8'h00, 1);
    n_total++;
    if ({f0, ec0, fc0, fa0, rc0} !== {5'b00100, 16'd1, 3'd2, 4'd9, 16'd1})
      $display("FAIL clr_with_error: flags=%b cnt=%0d code=%0d addr=%0d rd=%0d exp 00100 1 2 9 1",
               f0, ec0, fc0, fa0, rc0);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive(1, 1, 1, 4'd9, 8'h3C, 8'h00, 0);
    drive(0, 1, 0, 4'd0, 8'h00, 8'h00, 0);
    drive(1, 0, 0, 4'd2, 8'h00, 8'h00, 0);
    n_total++;
    if (f0 !== 5'b00100) $display("FAIL mid_reset_pre: flags=%b expected 00100", f0);
    else n_pass++;
    res = 1'b0;
    #1;
    n_total++;
    if (act0() !== 61'd0) $display("FAIL mid_reset_async0: got %h expected 0", act0());
    else n_pass++;
    n_total++;
    if (act1() !== 22'd0) $display("FAIL mid_reset_async1: got %h expected 0", act1());
    else n_pass++;
    model_reset();
    valid = 0; ready = 0;
    @(negedge clk);
    res = 1'b1;
    drive(1, 1, 0, 4'd9, 8'h00, 8'h00, 0);
    n_total++;
    if ({f0, rc0, f1} !== {5'b00000, 16'd1, 5'b10000})
      $display("FAIL mid_reset_read: f0=%b rd=%0d f1=%b expected 00000 1 10000", f0, rc0, f1);
    else n_pass++;
  endtask

  task automatic test_random();
    bit v, r, w, c;
    logic [3:0] a;
    logic [7:0] wd, rd;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (busy && $urandom_range(0, 99) < 88) begin
        v = 1; w = s_wr; a = s_addr; wd = s_wdata;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        w = 1'($urandom_range(0, 1));
        a = 4'($urandom_range(0, 7));
        wd = 8'($urandom);
      end
      r = ($urandom_range(0, 99) < 45);
      rd = (m_written[a] && $urandom_range(0, 3) != 0) ? m_shadow[a] : 8'($urandom);
      c = ($urandom_range(0, 99) < 3);
      drive(v, r, w, a, wd, rd, c);
      n_total++;
      if (act0() !== exp0())
        $display("FAIL random_dut0 cycle %0d: got %h expected %h", i, act0(), exp0());
      else n_pass++;
      n_total++;
      if (act1() !== exp1())
        $display("FAIL random_dut1 cycle %0d: got %h expected %h", i, act1(), exp1());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mismatch();
    test_timeout();
    test_unstable_spurious();
    test_strict_clear();
    test_clr_with_error();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
